// File: rtl/kernel_dispatch_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// kernel_dispatch_arbiter_pkg
// Shared definitions for the kernel dispatch arbiter:
//   - disp_state_t : dispatch FSM state encoding
//   - kid_width()  : engine-index width needed for a given engine count
// -----------------------------------------------------------------------------
package kernel_dispatch_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        START     = 2'd2
    } disp_state_t;

    // A single engine still needs a one-bit index.
    function automatic int kid_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/kernel_dispatch_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping from N-1 back to 0.
// Ports:
//   req       in  N   request vector
//   ptr       in  IW  starting index (always < N)
//   gnt_valid out 1   at least one request is set
//   gnt_idx   out IW  index of the granted request
// -----------------------------------------------------------------------------
module rr_pick
    import kernel_dispatch_arbiter_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = kid_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no path through the loops can infer a latch.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Offset i walks away from ptr; the inner loop keeps all indexing
        // constant so the picker unrolls into a plain priority mux.
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (!gnt_valid && req[k] && (k == (int'(ptr) + i) % N)) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = IW'(k);
                end
            end
        end
    end

endmodule

// File: rtl/kernel_dispatch_arbiter.sv
// -----------------------------------------------------------------------------
// kernel_dispatch_arbiter
// Pulls job descriptors one at a time, dispatches each to an idle engine
// (round-robin), tracks per-engine busy state, latches engine_done pulses and
// arbitrates completions (round-robin) into a single completion push.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   dsc_ready_i       descriptor available
//   dsc_pull_o        one-cycle pull strobe (data valid the following cycle)
//   dsc_data_i        descriptor
//   engine_start_o    one-hot start pulse
//   jd_payload_o      payload of the most recent dispatch
//   engine_done_i     per-engine done pulses
//   complete_ready_i  completion sink can accept
//   complete_push_o   one-cycle completion push
//   return_data_o     completion record (descriptor low bits)
//   return_kid_o      engine index of the pushed completion
//   busy_o            engine allocated and completion not yet pushed
//   err_spurious_o    sticky: done seen on a non-busy engine
// -----------------------------------------------------------------------------
module kernel_dispatch_arbiter
    import kernel_dispatch_arbiter_pkg::*;
#(
    parameter int KERNEL_NUM   = 2,
    parameter int HOST_DWIDTH  = 1024,
    parameter int RETURN_WIDTH = 41,
    parameter int KID_WIDTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dsc_ready_i,
    output logic                    dsc_pull_o,
    input  logic [HOST_DWIDTH-1:0]  dsc_data_i,
    output logic [KERNEL_NUM-1:0]   engine_start_o,
    output logic [HOST_DWIDTH-1:0]  jd_payload_o,
    input  logic [KERNEL_NUM-1:0]   engine_done_i,
    input  logic                    complete_ready_i,
    output logic                    complete_push_o,
    output logic [RETURN_WIDTH-1:0] return_data_o,
    output logic [KID_WIDTH-1:0]    return_kid_o,
    output logic [KERNEL_NUM-1:0]   busy_o,
    output logic                    err_spurious_o
);

    disp_state_t               state;
    logic [KID_WIDTH-1:0]      sel_kid;
    logic [KID_WIDTH-1:0]      disp_ptr;
    logic [KID_WIDTH-1:0]      cmpl_ptr;
    logic [KERNEL_NUM-1:0]     busy;
    logic [KERNEL_NUM-1:0]     pending;
    logic [RETURN_WIDTH-1:0]   tag [KERNEL_NUM];

    logic [KERNEL_NUM-1:0]     idle_mask;
    logic                      disp_valid;
    logic [KID_WIDTH-1:0]      disp_idx;
    logic                      cmpl_valid;
    logic [KID_WIDTH-1:0]      cmpl_idx;
    logic                      pull_fire;
    logic                      push_fire;
    logic [KERNEL_NUM-1:0]     set_mask;
    logic [KERNEL_NUM-1:0]     clr_mask;
    logic [RETURN_WIDTH-1:0]   tag_sel;

    function automatic logic [KERNEL_NUM-1:0] onehot(input logic [KID_WIDTH-1:0] idx);
        logic [KERNEL_NUM-1:0] oh;
        oh = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            if (idx == KID_WIDTH'(k)) oh[k] = 1'b1;
        end
        return oh;
    endfunction

    // Wraps at KERNEL_NUM-1, so with one engine the pointer stays 0.
    function automatic logic [KID_WIDTH-1:0] next_ptr(input logic [KID_WIDTH-1:0] idx);
        return (idx == KID_WIDTH'(KERNEL_NUM - 1)) ? '0 : idx + KID_WIDTH'(1);
    endfunction

    assign idle_mask = ~busy;
    assign busy_o    = busy;

    rr_pick #(.N(KERNEL_NUM), .IW(KID_WIDTH)) u_disp_pick (
        .req       (idle_mask),
        .ptr       (disp_ptr),
        .gnt_valid (disp_valid),
        .gnt_idx   (disp_idx)
    );

    rr_pick #(.N(KERNEL_NUM), .IW(KID_WIDTH)) u_cmpl_pick (
        .req       (pending),
        .ptr       (cmpl_ptr),
        .gnt_valid (cmpl_valid),
        .gnt_idx   (cmpl_idx)
    );

    assign pull_fire = (state == IDLE) && dsc_ready_i && disp_valid;
    assign push_fire = cmpl_valid && complete_ready_i;

    // The pull strobe must land in the same cycle the FSM decides, so it is
    // combinational; gating with rst keeps it low while reset is held.
    assign dsc_pull_o = pull_fire && !rst;

    // Set and clear never touch the same engine: set picks an idle engine,
    // clear picks a pending (hence busy) one.
    assign set_mask = pull_fire ? onehot(disp_idx) : '0;
    assign clr_mask = push_fire ? onehot(cmpl_idx) : '0;

    always_comb begin
        tag_sel = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            if (cmpl_idx == KID_WIDTH'(k)) tag_sel = tag[k];
        end
    end

    // Dispatch FSM with registered start pulse and payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            sel_kid        <= '0;
            disp_ptr       <= '0;
            engine_start_o <= '0;
            jd_payload_o   <= '0;
            // NOTE: the tag store is small and its contents are observable
            // through return_data_o, so it is cleared on reset like any
            // other register.
            for (int k = 0; k < KERNEL_NUM; k++) tag[k] <= '0;
        end else begin
            engine_start_o <= '0;
            case (state)
                IDLE: begin
                    if (pull_fire) begin
                        sel_kid <= disp_idx;
                        state   <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    jd_payload_o   <= dsc_data_i;
                    for (int k = 0; k < KERNEL_NUM; k++) begin
                        if (sel_kid == KID_WIDTH'(k)) tag[k] <= dsc_data_i[RETURN_WIDTH-1:0];
                    end
                    // Registered so the pulse is visible throughout START.
                    engine_start_o <= onehot(sel_kid);
                    state          <= START;
                end
                START: begin
                    disp_ptr <= next_ptr(sel_kid);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Busy / pending tracking and the completion push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy            <= '0;
            pending         <= '0;
            err_spurious_o  <= 1'b0;
            cmpl_ptr        <= '0;
            complete_push_o <= 1'b0;
            return_data_o   <= '0;
            return_kid_o    <= '0;
        end else begin
            busy    <= (busy | set_mask) & ~clr_mask;
            // A repeated done on an already-pending engine folds into the OR.
            pending <= (pending | (engine_done_i & busy)) & ~clr_mask;
            if (|(engine_done_i & ~busy)) err_spurious_o <= 1'b1;

            complete_push_o <= push_fire;
            if (push_fire) begin
                return_data_o <= tag_sel;
                return_kid_o  <= cmpl_idx;
                cmpl_ptr      <= next_ptr(cmpl_idx);
            end
        end
    end

endmodule
